// File: rtl/morse_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : morse_sequencer
// Purpose  : Morse keying controller. Accepts symbol indices over a
//            valid/ready handshake into a one-entry buffer, expands each
//            symbol into ITU element codes (DOT/DASH/GAP) and presents
//            them on o_p_data for a 3-bit shift-out register. That register
//            is clocked by the unit strobe o_shift and pulses i_next
//            whenever it loads o_p_data.
// Ports    : clk, rst_n       - clock, asynchronous active-low reset
//            i_char_valid     - requester offers a symbol
//            i_char_data[5:0] - 0-25 A-Z, 26-35 digits 0-9, 36 word space,
//                               37-63 invalid
//            o_char_ready     - buffer empty (symbol accepted on valid&ready)
//            o_err            - one-cycle pulse when an invalid index unloads
//            o_busy           - buffer full or sequencer not idle
//            o_shift          - one-cycle unit strobe every UNIT_CYCLES clocks
//            o_p_data[2:0]    - element code offered to the shift register
//            i_next           - shift register consumed o_p_data this cycle
// Revision : 1.0 - initial release
// ============================================================================
module morse_sequencer #(
  parameter int UNIT_CYCLES = 1200000,
  parameter int CNT_W       = 21
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_char_valid,
  input  logic [5:0] i_char_data,
  output logic       o_char_ready,
  output logic       o_err,
  output logic       o_busy,
  output logic       o_shift,
  output logic [2:0] o_p_data,
  input  logic       i_next
);

  localparam logic [CNT_W-1:0] c_UNIT_LAST = CNT_W'(UNIT_CYCLES - 1);
  localparam logic [2:0]       c_DOT       = 3'b001;
  localparam logic [2:0]       c_DASH      = 3'b111;
  localparam logic [2:0]       c_GAP       = 3'b000;
  localparam logic [5:0]       c_LAST_SYM  = 6'd35;
  localparam logic [5:0]       c_WORD_SP   = 6'd36;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ELEM = 3'd1,
    S_IGAP = 3'd2,
    S_LGAP = 3'd3,
    S_WGAP = 3'd4
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_unit_cnt;
  logic             r_buf_full;
  logic [5:0]       r_buf_data;
  logic [4:0]       r_pat;
  logic [2:0]       r_elem_cnt;
  logic [2:0]       r_gap_cnt;
  logic             r_err;
  logic [4:0]       w_dec_pat;
  logic [2:0]       w_dec_cnt;

  // Returns {element count, pattern}; pattern bit0 is the first element,
  // a 1 marks a dash. Non-letter/digit indices decode to zero (unused).
  function automatic logic [7:0] f_decode(input logic [5:0] idx);
    case (idx)
      6'd0:  f_decode = {3'd2, 5'b00010}; // A .-
      6'd1:  f_decode = {3'd4, 5'b00001}; // B -...
      6'd2:  f_decode = {3'd4, 5'b00101}; // C -.-.
      6'd3:  f_decode = {3'd3, 5'b00001}; // D -..
      6'd4:  f_decode = {3'd1, 5'b00000}; // E .
      6'd5:  f_decode = {3'd4, 5'b00100}; // F ..-.
      6'd6:  f_decode = {3'd3, 5'b00011}; // G --.
      6'd7:  f_decode = {3'd4, 5'b00000}; // H ....
      6'd8:  f_decode = {3'd2, 5'b00000}; // I ..
      6'd9:  f_decode = {3'd4, 5'b01110}; // J .---
      6'd10: f_decode = {3'd3, 5'b00101}; // K -.-
      6'd11: f_decode = {3'd4, 5'b00010}; // L .-..
      6'd12: f_decode = {3'd2, 5'b00011}; // M --
      6'd13: f_decode = {3'd2, 5'b00001}; // N -.
      6'd14: f_decode = {3'd3, 5'b00111}; // O ---
      6'd15: f_decode = {3'd4, 5'b00110}; // P .--.
      6'd16: f_decode = {3'd4, 5'b01011}; // Q --.-
      6'd17: f_decode = {3'd3, 5'b00010}; // R .-.
      6'd18: f_decode = {3'd3, 5'b00000}; // S ...
      6'd19: f_decode = {3'd1, 5'b00001}; // T -
      6'd20: f_decode = {3'd3, 5'b00100}; // U ..-
      6'd21: f_decode = {3'd4, 5'b01000}; // V ...-
      6'd22: f_decode = {3'd3, 5'b00110}; // W .--
      6'd23: f_decode = {3'd4, 5'b01001}; // X -..-
      6'd24: f_decode = {3'd4, 5'b01101}; // Y -.--
      6'd25: f_decode = {3'd4, 5'b00011}; // Z --..
      6'd26: f_decode = {3'd5, 5'b11111}; // 0 -----
      6'd27: f_decode = {3'd5, 5'b11110}; // 1 .----
      6'd28: f_decode = {3'd5, 5'b11100}; // 2 ..---
      6'd29: f_decode = {3'd5, 5'b11000}; // 3 ...--
      6'd30: f_decode = {3'd5, 5'b10000}; // 4 ....-
      6'd31: f_decode = {3'd5, 5'b00000}; // 5 .....
      6'd32: f_decode = {3'd5, 5'b00001}; // 6 -....
      6'd33: f_decode = {3'd5, 5'b00011}; // 7 --...
      6'd34: f_decode = {3'd5, 5'b00111}; // 8 ---..
      6'd35: f_decode = {3'd5, 5'b01111}; // 9 ----.
      default: f_decode = 8'd0;
    endcase
  endfunction

  assign {w_dec_cnt, w_dec_pat} = f_decode(r_buf_data);

  // Free-running unit timer; the strobe keeps running while idle so the
  // shift register always has a time base.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_unit_cnt <= '0;
    end else if (r_unit_cnt == c_UNIT_LAST) begin
      r_unit_cnt <= '0;
    end else begin
      r_unit_cnt <= r_unit_cnt + CNT_W'(1);
    end
  end

  assign o_shift = (r_unit_cnt == c_UNIT_LAST);

  // Buffer and element sequencer. A write needs an empty buffer and an
  // unload needs a full one, so the two never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_buf_full <= 1'b0;
      r_buf_data <= '0;
      r_pat      <= '0;
      r_elem_cnt <= '0;
      r_gap_cnt  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= 1'b0;

      if (i_char_valid && !r_buf_full) begin
        r_buf_full <= 1'b1;
        r_buf_data <= i_char_data;
      end

      case (r_state)
        // A next here only burns a GAP unit; the unload ignores it.
        S_IDLE: begin
          if (r_buf_full) begin
            r_buf_full <= 1'b0;
            if (r_buf_data <= c_LAST_SYM) begin
              r_pat      <= w_dec_pat;
              r_elem_cnt <= w_dec_cnt;
              r_state    <= S_ELEM;
            end else if (r_buf_data == c_WORD_SP) begin
              // LGAP of the previous letter already supplied 3 units.
              r_gap_cnt <= 3'd4;
              r_state   <= S_WGAP;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_ELEM: begin
          if (i_next) begin
            if (r_elem_cnt > 3'd1) begin
              r_pat      <= r_pat >> 1;
              r_elem_cnt <= r_elem_cnt - 3'd1;
              r_state    <= S_IGAP;
            end else begin
              r_gap_cnt <= 3'd3;
              r_state   <= S_LGAP;
            end
          end
        end
        S_IGAP: begin
          if (i_next) begin
            r_state <= S_ELEM;
          end
        end
        S_LGAP, S_WGAP: begin
          if (i_next) begin
            r_gap_cnt <= r_gap_cnt - 3'd1;
            if (r_gap_cnt == 3'd1) begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_p_data = c_GAP;
    if (r_state == S_ELEM) begin
      o_p_data = r_pat[0] ? c_DASH : c_DOT;
    end
  end

  assign o_char_ready = !r_buf_full;
  assign o_busy       = r_buf_full || (r_state != S_IDLE);
  assign o_err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_morse_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_morse_sequencer
// Purpose  : Self-checking bench for morse_sequencer with a behavioural
//            3-bit shift-out register attached. Expected S_DATA streams are
//            queued per symbol and compared one unit at a time.
// Revision : 1.0 - initial release
// ============================================================================
module tb_morse_sequencer;

  localparam int UNIT = 4;

  logic       clk          = 1'b0;
  logic       rst_n        = 1'b0;
  logic       i_char_valid = 1'b0;
  logic [5:0] i_char_data  = 6'd0;
  logic       i_next       = 1'b0;
  logic       o_char_ready;
  logic       o_err;
  logic       o_busy;
  logic       o_shift;
  logic [2:0] o_p_data;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];

  // Shift-register model state
  logic       s_data   = 1'b0;
  logic [2:0] sr_bits  = 3'b000;
  int         sr_rem   = 0;
  int         tick_cnt = 0;

  morse_sequencer #(
    .UNIT_CYCLES(UNIT),
    .CNT_W      (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_char_valid(i_char_valid),
    .i_char_data (i_char_data),
    .o_char_ready(o_char_ready),
    .o_err       (o_err),
    .o_busy      (o_busy),
    .o_shift     (o_shift),
    .o_p_data    (o_p_data),
    .i_next      (i_next)
  );

  always #5 clk = ~clk;

  // Shift-out register: on each unit strobe it either loads a new code
  // (pulsing next for the coming edge) or shifts out the next bit.
  // Code length is given by its highest set bit; GAP lasts one unit.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_data  = 1'b0;
      sr_bits = 3'b000;
      sr_rem  = 0;
      i_next  = 1'b0;
    end else begin
      i_next = 1'b0;
      if (o_shift) begin
        if (sr_rem == 0) begin
          sr_bits = o_p_data;
          sr_rem  = o_p_data[2] ? 2 : (o_p_data[1] ? 1 : 0);
          i_next  = 1'b1;
        end else begin
          sr_rem = sr_rem - 1;
        end
        s_data   = sr_bits[0];
        sr_bits  = sr_bits >> 1;
        tick_cnt = tick_cnt + 1;
      end
    end
  end

  // Returns 1 ns after the clock edge that follows the next unit strobe.
  task automatic wait_tick();
    int t0  = tick_cnt;
    bit got = 1'b0;
    for (int i = 0; i < 4 * UNIT + 8 && !got; i++) begin
      @(posedge clk);
      #1;
      if (tick_cnt != t0) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: no shift strobe within %0d cycles", 4 * UNIT + 8);
    end
  endtask

  task automatic send_sym(input logic [5:0] sym);
    bit rdy;
    bit done = 1'b0;
    i_char_valid = 1'b1;
    i_char_data  = sym;
    for (int i = 0; i < 200 && !done; i++) begin
      rdy = o_char_ready;
      @(posedge clk);
      #1;
      if (rdy) done = 1'b1;
    end
    i_char_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: symbol %0d never accepted", sym);
    end
  endtask

  task automatic push_bits(input int n, input bit v);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks += 5;
    if (o_shift !== 1'b0) begin errors++; $display("FAIL rst_shift: got %b expected 0", o_shift); end
    if (o_p_data !== 3'b000) begin errors++; $display("FAIL rst_p_data: got %b expected 000", o_p_data); end
    if (o_char_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", o_char_ready); end
    if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", o_busy); end
    if (o_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", o_err); end
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    // Strobe must be sampled high at the UNIT-th rising edge after release.
    for (int k = 1; k <= UNIT; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (o_shift !== (k == UNIT - 1)) begin
        errors++;
        $display("FAIL rst_first_shift edge %0d: got %b expected %b", k, o_shift, (k == UNIT - 1));
      end
    end
  endtask

  task automatic test_letter_a();
    bit e;
    int n = 0;
    wait_tick();
    checks++;
    if (s_data !== 1'b0) begin errors++; $display("FAIL a_pre_unit: got %b expected 0", s_data); end
    exp_q.delete();
    push_bits(1, 1'b1); push_bits(1, 1'b0); push_bits(3, 1'b1); push_bits(5, 1'b0);
    send_sym(6'd0);
    while (exp_q.size() > 0) begin
      wait_tick();
      e = exp_q.pop_front();
      checks += 2;
      if (s_data !== e) begin errors++; $display("FAIL a_sdata unit %0d: got %b expected %b", n, s_data, e); end
      // busy drops on the third LGAP consumption (8th unit)
      if (o_busy !== (n < 7)) begin errors++; $display("FAIL a_busy unit %0d: got %b expected %b", n, o_busy, (n < 7)); end
      n++;
    end
  endtask

  task automatic test_back_to_back();
    bit e;
    int n  = 0;
    int t0;
    wait_tick();
    t0 = tick_cnt;
    exp_q.delete();
    push_bits(1, 1'b1); push_bits(3, 1'b0); push_bits(3, 1'b1); push_bits(4, 1'b0);
    fork
      begin
        send_sym(6'd4);
        send_sym(6'd19);
        checks++;
        if (tick_cnt - t0 >= 4) begin
          errors++;
          $display("FAIL b2b_early_ready: T accepted after %0d units, expected under 4", tick_cnt - t0);
        end
      end
      begin
        while (exp_q.size() > 0) begin
          wait_tick();
          e = exp_q.pop_front();
          checks++;
          if (s_data !== e) begin errors++; $display("FAIL b2b_sdata unit %0d: got %b expected %b", n, s_data, e); end
          n++;
        end
      end
    join
  endtask

  task automatic test_digit_zero();
    bit e;
    int n = 0;
    wait_tick();
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      push_bits(3, 1'b1);
      if (i < 4) push_bits(1, 1'b0);
    end
    push_bits(3, 1'b0);
    send_sym(6'd26);
    while (exp_q.size() > 0) begin
      wait_tick();
      e = exp_q.pop_front();
      checks++;
      if (s_data !== e) begin errors++; $display("FAIL zero_sdata unit %0d: got %b expected %b", n, s_data, e); end
      n++;
    end
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL zero_busy_end: got %b expected 0", o_busy); end
  endtask

  task automatic test_word_space();
    bit e;
    int n = 0;
    wait_tick();
    exp_q.delete();
    push_bits(1, 1'b1); push_bits(7, 1'b0); push_bits(1, 1'b1); push_bits(3, 1'b0);
    fork
      begin
        send_sym(6'd4);
        send_sym(6'd36);
        send_sym(6'd4);
      end
      begin
        while (exp_q.size() > 0) begin
          wait_tick();
          e = exp_q.pop_front();
          checks++;
          if (s_data !== e) begin errors++; $display("FAIL word_sdata unit %0d: got %b expected %b", n, s_data, e); end
          n++;
        end
      end
    join
  endtask

  task automatic test_invalid();
    logic [5:0] bad [3] = '{6'd37, 6'd45, 6'd63};
    for (int s = 0; s < 3; s++) begin
      wait_tick();
      send_sym(bad[s]);
      // cycle after acceptance: buffer holds the symbol
      checks += 2;
      if (o_char_ready !== 1'b0) begin errors++; $display("FAIL inv%0d_ready_c1: got %b expected 0", bad[s], o_char_ready); end
      if (o_err !== 1'b0) begin errors++; $display("FAIL inv%0d_err_c1: got %b expected 0", bad[s], o_err); end
      @(posedge clk);
      #1;
      checks += 4;
      if (o_char_ready !== 1'b1) begin errors++; $display("FAIL inv%0d_ready_c2: got %b expected 1", bad[s], o_char_ready); end
      if (o_err !== 1'b1) begin errors++; $display("FAIL inv%0d_err_c2: got %b expected 1", bad[s], o_err); end
      if (o_busy !== 1'b0) begin errors++; $display("FAIL inv%0d_busy: got %b expected 0", bad[s], o_busy); end
      if (o_p_data !== 3'b000) begin errors++; $display("FAIL inv%0d_p_data: got %b expected 000", bad[s], o_p_data); end
      @(posedge clk);
      #1;
      checks++;
      if (o_err !== 1'b0) begin errors++; $display("FAIL inv%0d_err_c3: got %b expected 0", bad[s], o_err); end
      for (int u = 0; u < 2; u++) begin
        wait_tick();
        checks++;
        if (s_data !== 1'b0) begin errors++; $display("FAIL inv%0d_sdata unit %0d: got %b expected 0", bad[s], u, s_data); end
      end
    end
  endtask

  task automatic test_reset_mid_symbol();
    wait_tick();
    send_sym(6'd19);
    wait_tick();
    checks++;
    if (s_data !== 1'b1) begin errors++; $display("FAIL rmid_dash_on: got %b expected 1", s_data); end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks += 6;
    if (o_shift !== 1'b0) begin errors++; $display("FAIL rmid_shift: got %b expected 0", o_shift); end
    if (o_p_data !== 3'b000) begin errors++; $display("FAIL rmid_p_data: got %b expected 000", o_p_data); end
    if (o_char_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b expected 1", o_char_ready); end
    if (o_busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected 0", o_busy); end
    if (o_err !== 1'b0) begin errors++; $display("FAIL rmid_err: got %b expected 0", o_err); end
    if (s_data !== 1'b0) begin errors++; $display("FAIL rmid_sdata: got %b expected 0", s_data); end
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    for (int k = 1; k <= UNIT; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (o_shift !== (k == UNIT - 1)) begin
        errors++;
        $display("FAIL rmid_shift_edge %0d: got %b expected %b", k, o_shift, (k == UNIT - 1));
      end
    end
    // partial symbol is gone: the key stays up
    for (int u = 0; u < 3; u++) begin
      wait_tick();
      checks += 2;
      if (s_data !== 1'b0) begin errors++; $display("FAIL rmid_after_sdata unit %0d: got %b expected 0", u, s_data); end
      if (o_busy !== 1'b0) begin errors++; $display("FAIL rmid_after_busy unit %0d: got %b expected 0", u, o_busy); end
    end
  endtask

  initial begin
    test_reset();
    test_letter_a();
    test_back_to_back();
    test_digit_zero();
    test_word_space();
    test_invalid();
    test_reset_mid_symbol();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/morse_sequencer.md
# morse_sequencer

Morse keying controller that drives the 3-bit Morse shift-out register. It accepts symbol indices from a requester over a valid/ready handshake, holds one symbol in a one-entry buffer, and expands it into ITU element codes. It generates the unit-time `shift` strobe and presents the element code on `p_data` for the shift register to load whenever that register pulses `next`. It sits between the character source (UART/keyboard front end) and the shift register, whose `S_DATA` drives the key/LED.

## Interface
- `UNIT_CYCLES`, default 1200000: clk cycles per Morse time unit. Minimum 2.
- `CNT_W`, default 21: width of the unit counter; must satisfy 2^CNT_W ≥ UNIT_CYCLES.
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `char_valid` input 1: requester offers a symbol.
- `char_data` input 6: symbol index.
  - 0–25: A–Z.
  - 26–35: digits 0–9.
  - 36: word space.
  - 37–63: invalid.
- `char_ready` output 1: buffer empty; a symbol is accepted when `char_valid && char_ready` at a clk edge.
- `err` output 1: one-cycle pulse when an invalid index leaves the buffer.
- `busy` output 1: the buffer is full or the FSM is not in IDLE.
- `shift` output 1: unit strobe to the shift register.
- `p_data` output 3: element code presented to the shift register.
- `next` input 1: shift register consumed `p_data` this cycle.

## Operation
- Element codes are emitted LSB-first by the shift register, and their length is set by the highest set bit.
  - DOT = 3'b001: 1 unit on.
  - DASH = 3'b111: 3 units on.
  - GAP = 3'b000: 1 unit off.
- Tick generator:
  - Free-running counter, 0 to UNIT_CYCLES-1, wrapping.
  - `shift` is high for exactly one cycle when the counter equals UNIT_CYCLES-1.
  - It never stops, including when idle.
- Buffer:
  - `char_ready` = buffer empty.
  - An accepted symbol is stored.
- Decode uses ITU-R M.1677-1 patterns: pattern register 5 bits (bit0 = first element, 1 = dash) plus remaining-element count 1–5.
- FSM states: IDLE, ELEM, IGAP, LGAP, WGAP. `p_data` is a combinational function of state: ELEM gives DOT or DASH from pattern bit0; every other state gives GAP.
- IDLE:
  - With the buffer full, the FSM acts on the next clk edge, independent of `next`, and empties the buffer.
    - Index 0–35 → ELEM, with pattern and count loaded.
    - Index 36 → WGAP, with gap count 4.
    - Index 37–63 → stay in IDLE and pulse `err`.
  - A `next` in IDLE consumes a GAP unit; there is no state change.
- ELEM on `next`:
  - If count > 1: shift the pattern right, decrement count, go to IGAP.
  - Otherwise: go to LGAP with gap count 3.
- IGAP on `next`: go to ELEM.
- LGAP and WGAP on `next`: decrement the gap count. On the consumption that brings it to 0, go to IDLE.
- Resulting timing:
  - Inter-element gap: 1 unit.
  - Letter gap: at least 3 units.
  - Word gap: at least 7 units (LGAP 3 + WGAP 4).
- The buffer may accept a new symbol while the FSM is in any state, so back-to-back symbols have no extra gap beyond the rules above.

## Timing
- Reset values: `shift` 0, `p_data` 3'b000, `char_ready` 1, `busy` 0, `err` 0. Reset also clears the unit counter, FSM (IDLE), buffer, pattern and count.
- The first `shift` is at the UNIT_CYCLES-th rising edge after reset deassertion.
- Handshake:
  - `char_ready` falls the cycle after acceptance.
  - It rises the cycle after the buffer is unloaded in IDLE.
  - `char_data` is sampled only on acceptance.
  - Holding `char_valid` with `char_ready` low has no effect.
- Buffer-to-FSM load latency is 1 cycle.
- When `next` and a buffer write coincide, both take effect.
- When `next` and the IDLE unload coincide, the IDLE `next` consumes GAP and the unload still occurs.
- `err` is asserted the cycle after the unload edge, for 1 cycle.
- Reset mid-symbol: everything returns to reset values immediately, and the partial symbol is lost.

## Test plan
- Symbol-level scenarios use UNIT_CYCLES=4 with the shift register attached. S_DATA is listed per unit, starting with the unit before the first tick.
- Send 'A' (0) after reset → S_DATA 0,1,0,1,1,1,0,0,0 then 0 forever. `busy` falls after the third LGAP `next`.
- Send 'E' (4), then 'T' (19), back-to-back → S_DATA 0,1,0,0,0,1,1,1,0,0,0. The second `char_ready` is granted while the first symbol is still keying.
- Send '0' (26) → five DASHes separated by single GAPs: 19 units on/off total before LGAP. Pattern 111 0 111 0 111 0 111 0 111.
- Send 'E', then 36, then 'E' → 1 unit on, exactly 7 units off, 1 unit on.
- Send 45 → `err` is a single-cycle pulse. No non-zero S_DATA, `char_ready` returns to 1 after 2 cycles, and the FSM stays in IDLE.
- Assert `rst_n` low mid-DASH of 'T', then release → all outputs at reset values, S_DATA 0, and the next `shift` arrives after UNIT_CYCLES cycles.
